// File: rtl/pdp8i_pkg.sv
// -----------------------------------------------------------------------------
// pdp8i_pkg
// Shared types and helpers for the pulse-amplifier blocks.
//   pa_state_t : per-channel pulse amplifier state (idle / pulse / recover)
//   cnt_width  : counter width able to hold max(pw, rec)
// -----------------------------------------------------------------------------
package pdp8i_pkg;

  typedef enum logic [1:0] {
    PA_IDLE    = 2'd0,
    PA_PULSE   = 2'd1,
    PA_RECOVER = 2'd2
  } pa_state_t;

  // Width of a down-counter that must hold values up to max(pw, rec).
  function automatic int cnt_width(input int pw, input int rec);
    int top_val;
    top_val = (pw > rec) ? pw : rec;
    return (top_val < 1) ? 1 : $clog2(top_val + 1);
  endfunction

endpackage

// File: rtl/m602_chan.sv
// -----------------------------------------------------------------------------
// m602_chan
// One pulse-amplifier channel. A falling trigger level (or an external edge
// strobe, when use_ext is set) qualified by en starts a pulse PW cycles wide,
// followed by REC recovery cycles in which new triggers are refused and
// flagged on the sticky miss output.
// Ports:
//   clk, reset      : master clock, synchronous active-high reset
//   trig, en        : trigger level and conditioning level
//   use_ext         : 1 = take the edge from ext_edge instead of trig
//   ext_edge        : external edge strobe (already a one-cycle event)
//   pulse, pulse_n  : active-high pulse and its exact complement
//   busy            : high in PULSE or RECOVER
//   miss            : sticky, set by a refused trigger
//   pulse_end       : high in the last pulse cycle (pulse falls on next edge)
// -----------------------------------------------------------------------------
module m602_chan
  import pdp8i_pkg::*;
#(
  parameter int PW  = 4,
  parameter int REC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic trig,
  input  logic en,
  input  logic use_ext,
  input  logic ext_edge,
  output logic pulse,
  output logic pulse_n,
  output logic busy,
  output logic miss,
  output logic pulse_end
);

  localparam int CW = cnt_width(PW, REC);
  localparam logic [CW-1:0] PW_LOAD  = CW'(PW - 1);
  localparam logic [CW-1:0] REC_LOAD = CW'((REC > 0) ? REC - 1 : 0);

  pa_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          prev;
  logic          miss_nx;
  logic          edge_seen;
  logic          fire;

  // prev always follows trig, even when the edge comes from ext_edge.
  assign edge_seen = use_ext ? ext_edge : (prev & ~trig);
  assign fire      = edge_seen & en;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PA_IDLE;
      cnt   <= '0;
      prev  <= 1'b0;
      miss  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      prev  <= trig;
      miss  <= miss_nx;
    end
  end

  // NOTE: every output of this block is given its hold value first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    miss_nx  = miss;
    unique case (state)
      PA_IDLE: begin
        if (fire) begin
          state_nx = PA_PULSE;
          cnt_nx   = PW_LOAD;
        end
      end
      PA_PULSE: begin
        // A trigger during the pulse never restarts or stretches it.
        miss_nx = miss | fire;
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (REC == 0) begin
          state_nx = PA_IDLE;
          cnt_nx   = '0;
        end else begin
          state_nx = PA_RECOVER;
          cnt_nx   = REC_LOAD;
        end
      end
      PA_RECOVER: begin
        if (cnt != '0) begin
          cnt_nx  = cnt - CW'(1);
          miss_nx = miss | fire;
        end else if (fire) begin
          // Last recovery cycle: a trigger here is already accepted, which
          // gives the PW+REC minimum period.
          state_nx = PA_PULSE;
          cnt_nx   = PW_LOAD;
        end else begin
          state_nx = PA_IDLE;
        end
      end
      default: begin
        state_nx = PA_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign pulse     = (state == PA_PULSE);
  assign pulse_n   = ~pulse;
  assign busy      = (state != PA_IDLE);
  assign pulse_end = (state == PA_PULSE) && (cnt == '0);

endmodule

// File: rtl/m602.sv
// -----------------------------------------------------------------------------
// m602
// Two-channel pulse amplifier driving the clk_n inputs of the JK flip-flops.
// Each channel converts a sampled 1->0 trigger transition into a PW-cycle
// pulse followed by REC recovery cycles. With CHAIN=1 channel 1 is started by
// the trailing edge of channel 0 instead of by trig1.
// Ports:
//   clk, reset          : master clock, synchronous active-high reset
//   trig0/1, en0/1      : trigger and conditioning levels
//   pulse0/1, pulse0/1_n: active-high pulse and its complement (to clk_n)
//   busy0/1             : channel in PULSE or RECOVER
//   miss0/1             : sticky refused-trigger flags
// -----------------------------------------------------------------------------
module m602
  import pdp8i_pkg::*;
#(
  parameter int PW    = 4,
  parameter int REC   = 2,
  parameter int CHAIN = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic trig0,
  input  logic trig1,
  input  logic en0,
  input  logic en1,
  output logic pulse0,
  output logic pulse1,
  output logic pulse0_n,
  output logic pulse1_n,
  output logic busy0,
  output logic busy1,
  output logic miss0,
  output logic miss1
);

  if (PW < 1 || REC < 0 || (CHAIN != 0 && CHAIN != 1)) begin : g_bad_params
    $error("m602: illegal parameters PW=%0d REC=%0d CHAIN=%0d", PW, REC, CHAIN);
  end

  localparam logic USE_CHAIN = (CHAIN == 1);

  logic end0;
  logic unused_end1;

  m602_chan #(.PW(PW), .REC(REC)) u_ch0 (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig0),
    .en        (en0),
    .use_ext   (1'b0),
    .ext_edge  (1'b0),
    .pulse     (pulse0),
    .pulse_n   (pulse0_n),
    .busy      (busy0),
    .miss      (miss0),
    .pulse_end (end0)
  );

  // end0 is combinational, so channel 1 rises on the edge channel 0 falls.
  m602_chan #(.PW(PW), .REC(REC)) u_ch1 (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig1),
    .en        (en1),
    .use_ext   (USE_CHAIN),
    .ext_edge  (end0),
    .pulse     (pulse1),
    .pulse_n   (pulse1_n),
    .busy      (busy1),
    .miss      (miss1),
    .pulse_end (unused_end1)
  );

endmodule

// File: tb/tb_m602.sv
// -----------------------------------------------------------------------------
// tb_m602
// Three m602 instances: A (PW=4, REC=2), C (PW=3, REC=2, chained) and
// M (PW=1, REC=0). Directed table and hand sequences, then random stimulus
// checked against a timestamp-based reference model.
// -----------------------------------------------------------------------------
module tb_m602;

  localparam int ND = 3;
  localparam int PW_A = 4, REC_A = 2;
  localparam int PW_C = 3, REC_C = 2;
  localparam int PW_M = 1, REC_M = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst     [ND];
  logic trig    [ND][2];
  logic en      [ND][2];
  logic pulse   [ND][2];
  logic pulse_n [ND][2];
  logic busy    [ND][2];
  logic miss    [ND][2];

  m602 #(.PW(PW_A), .REC(REC_A), .CHAIN(0)) dut_a (
    .clk(clk), .reset(rst[0]), .trig0(trig[0][0]), .trig1(trig[0][1]),
    .en0(en[0][0]), .en1(en[0][1]),
    .pulse0(pulse[0][0]), .pulse1(pulse[0][1]),
    .pulse0_n(pulse_n[0][0]), .pulse1_n(pulse_n[0][1]),
    .busy0(busy[0][0]), .busy1(busy[0][1]),
    .miss0(miss[0][0]), .miss1(miss[0][1]));

  m602 #(.PW(PW_C), .REC(REC_C), .CHAIN(1)) dut_c (
    .clk(clk), .reset(rst[1]), .trig0(trig[1][0]), .trig1(trig[1][1]),
    .en0(en[1][0]), .en1(en[1][1]),
    .pulse0(pulse[1][0]), .pulse1(pulse[1][1]),
    .pulse0_n(pulse_n[1][0]), .pulse1_n(pulse_n[1][1]),
    .busy0(busy[1][0]), .busy1(busy[1][1]),
    .miss0(miss[1][0]), .miss1(miss[1][1]));

  m602 #(.PW(PW_M), .REC(REC_M), .CHAIN(0)) dut_m (
    .clk(clk), .reset(rst[2]), .trig0(trig[2][0]), .trig1(trig[2][1]),
    .en0(en[2][0]), .en1(en[2][1]),
    .pulse0(pulse[2][0]), .pulse1(pulse[2][1]),
    .pulse0_n(pulse_n[2][0]), .pulse1_n(pulse_n[2][1]),
    .busy0(busy[2][0]), .busy1(busy[2][1]),
    .miss0(miss[2][0]), .miss1(miss[2][1]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a channel remembers the edge number at which its
  // current pulse was accepted. Pulse covers edges [start, start+PW),
  // busy covers [start, start+PW+REC), next accept allowed at start+PW+REC.
  int m_pw [ND];
  int m_rec[ND];
  bit m_chain[ND];
  int m_start[ND][2];
  bit m_act  [ND][2];
  bit m_miss [ND][2];
  bit m_prev [ND][2];

  function automatic bit exp_pulse(input int d, input int c);
    return m_act[d][c] && (cyc < m_start[d][c] + m_pw[d]);
  endfunction

  function automatic bit exp_busy(input int d, input int c);
    return m_act[d][c] && (cyc < m_start[d][c] + m_pw[d] + m_rec[d]);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      bit ch0_falls;
      if (rst[d]) begin
        for (int c = 0; c < 2; c++) begin
          m_act[d][c]  = 1'b0;
          m_miss[d][c] = 1'b0;
          m_prev[d][c] = 1'b0;
        end
        continue;
      end
      ch0_falls = m_act[d][0] && (cyc == m_start[d][0] + m_pw[d]);
      for (int c = 0; c < 2; c++) begin
        bit fire, ok;
        fire = (c == 1 && m_chain[d]) ? ch0_falls : (m_prev[d][c] && !trig[d][c]);
        fire = fire && en[d][c];
        ok   = !m_act[d][c] || (cyc >= m_start[d][c] + m_pw[d] + m_rec[d]);
        if (fire && ok) begin
          m_act[d][c]   = 1'b1;
          m_start[d][c] = cyc;
        end else if (fire) begin
          m_miss[d][c] = 1'b1;
        end
        m_prev[d][c] = trig[d][c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_model(input int d);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("rnd d%0d.pulse%0d", d, c),   pulse[d][c],   exp_pulse(d, c));
      check($sformatf("rnd d%0d.pulse%0d_n", d, c), pulse_n[d][c], !exp_pulse(d, c));
      check($sformatf("rnd d%0d.busy%0d", d, c),    busy[d][c],    exp_busy(d, c));
      check($sformatf("rnd d%0d.miss%0d", d, c),    miss[d][c],    m_miss[d][c]);
    end
  endtask

  // Directed vector for instance A: inputs then expected outputs.
  typedef struct packed {
    logic rst, t0, e0, t1, e1;
    logic p0, b0, m0, p1, b1, m1;
  } vec_t;

  vec_t tbl[23];

  initial begin
    m_pw  = '{PW_A, PW_C, PW_M};
    m_rec = '{REC_A, REC_C, REC_M};
    m_chain = '{1'b0, 1'b1, 1'b0};
    for (int d = 0; d < ND; d++) begin
      rst[d] = 1'b1;
      for (int c = 0; c < 2; c++) begin
        trig[d][c] = 1'b1; en[d][c] = 1'b1;
        m_start[d][c] = 0; m_act[d][c] = 1'b0;
        m_miss[d][c] = 1'b0; m_prev[d][c] = 1'b0;
      end
    end

    //          rst t0 e0 t1 e1   p0 b0 m0 p1 b1 m1
    tbl[0]  = 11'b1_1_1_1_0__0_0_0_0_0_0;
    tbl[1]  = 11'b0_1_1_1_0__0_0_0_0_0_0;
    tbl[2]  = 11'b0_1_1_1_0__0_0_0_0_0_0;
    tbl[3]  = 11'b0_1_1_1_0__0_0_0_0_0_0;
    tbl[4]  = 11'b0_1_1_1_0__0_0_0_0_0_0;
    tbl[5]  = 11'b0_1_1_0_0__0_0_0_0_0_0;  // trig1 falls, en1=0: ignored
    tbl[6]  = 11'b0_1_1_1_1__0_0_0_0_0_0;
    tbl[7]  = 11'b0_1_1_1_1__0_0_0_0_0_0;
    tbl[8]  = 11'b0_1_1_0_1__0_0_0_1_1_0;  // ch1 pulse starts
    tbl[9]  = 11'b0_1_1_1_1__0_0_0_1_1_0;
    tbl[10] = 11'b0_0_1_1_0__1_1_0_1_1_0;  // ch0 pulse starts; en1 dropped
    tbl[11] = 11'b0_1_1_0_0__1_1_0_1_1_0;  // trig1 falls with en1=0: no miss
    tbl[12] = 11'b0_0_1_1_0__1_1_1_0_1_0;  // ch0 retrigger while pulsing
    tbl[13] = 11'b0_1_1_1_0__1_1_1_0_1_0;
    tbl[14] = 11'b0_1_1_1_0__0_1_1_0_0_0;
    tbl[15] = 11'b0_1_1_1_0__0_1_1_0_0_0;
    tbl[16] = 11'b0_0_1_1_0__1_1_1_0_0_0;  // earliest accepted retrigger
    tbl[17] = 11'b0_0_1_1_0__1_1_1_0_0_0;
    tbl[18] = 11'b0_1_1_1_0__1_1_1_0_0_0;
    tbl[19] = 11'b0_1_1_1_0__1_1_1_0_0_0;
    tbl[20] = 11'b0_1_1_1_0__0_1_1_0_0_0;
    tbl[21] = 11'b0_1_1_1_0__0_1_1_0_0_0;
    tbl[22] = 11'b0_1_1_1_0__0_0_1_0_0_0;

    // ---- table phase on instance A (others held in reset) ----
    for (int i = 0; i < 23; i++) begin
      rst[0] = tbl[i].rst;
      trig[0][0] = tbl[i].t0; en[0][0] = tbl[i].e0;
      trig[0][1] = tbl[i].t1; en[0][1] = tbl[i].e1;
      tick();
      check($sformatf("tbl%0d.pulse0", i),   pulse[0][0],   tbl[i].p0);
      check($sformatf("tbl%0d.pulse0_n", i), pulse_n[0][0], ~tbl[i].p0);
      check($sformatf("tbl%0d.busy0", i),    busy[0][0],    tbl[i].b0);
      check($sformatf("tbl%0d.miss0", i),    miss[0][0],    tbl[i].m0);
      check($sformatf("tbl%0d.pulse1", i),   pulse[0][1],   tbl[i].p1);
      check($sformatf("tbl%0d.pulse1_n", i), pulse_n[0][1], ~tbl[i].p1);
      check($sformatf("tbl%0d.busy1", i),    busy[0][1],    tbl[i].b1);
      check($sformatf("tbl%0d.miss1", i),    miss[0][1],    tbl[i].m1);
    end

    // ---- reset mid-pulse with trig0 held low through release ----
    trig[0][0] = 1'b1; en[0][0] = 1'b1;
    tick(); tick();
    trig[0][0] = 1'b0; tick();
    check("rst.pulse_started", pulse[0][0], 1'b1);
    tick();
    rst[0] = 1'b1; tick();
    check("rst.pulse0", pulse[0][0], 1'b0);
    check("rst.busy0",  busy[0][0],  1'b0);
    check("rst.miss0",  miss[0][0],  1'b0);
    rst[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst.low_hold%0d", i), pulse[0][0], 1'b0);
    end
    trig[0][0] = 1'b1; tick();
    check("rst.rise", pulse[0][0], 1'b0);
    trig[0][0] = 1'b0; tick();
    check("rst.refall", pulse[0][0], 1'b1);
    trig[0][0] = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    // reset dominates a simultaneous fire
    trig[0][0] = 1'b0; rst[0] = 1'b1; tick();
    check("rstdom.pulse0", pulse[0][0], 1'b0);
    check("rstdom.busy0",  busy[0][0],  1'b0);
    rst[0] = 1'b0; trig[0][0] = 1'b1; tick();
    check("rstdom.after", pulse[0][0], 1'b0);

    // ---- chaining on instance C: trig0 falls at relative edge 5 ----
    rst[1] = 1'b1; tick();
    rst[1] = 1'b0;
    en[1][0] = 1'b1; en[1][1] = 1'b1; trig[1][0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      trig[1][0] = (e == 5) ? 1'b0 : 1'b1;
      trig[1][1] = 1'($urandom_range(0, 1));
      tick();
      if (e >= 5) begin
        check($sformatf("chain%0d.pulse0", e), pulse[1][0], (e >= 5 && e <= 7));
        check($sformatf("chain%0d.pulse1", e), pulse[1][1], (e >= 8 && e <= 10));
        check($sformatf("chain%0d.miss1", e),  miss[1][1],  1'b0);
      end
    end

    // ---- minimum settings on instance M: a fall every 2 cycles ----
    rst[2] = 1'b1; tick();
    rst[2] = 1'b0; en[2][0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      trig[2][0] = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("min%0d.pulse0", i), pulse[2][0], (i % 2 == 1));
      check($sformatf("min%0d.busy0", i),  busy[2][0],  (i % 2 == 1));
      check($sformatf("min%0d.miss0", i),  miss[2][0],  1'b0);
    end

    // ---- randomized phase, all instances against the model ----
    for (int d = 0; d < ND; d++) rst[d] = 1'b1;
    tick();
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < ND; d++) begin
        rst[d] = ($urandom_range(0, 199) == 0);
        for (int c = 0; c < 2; c++) begin
          trig[d][c] = 1'($urandom_range(0, 1));
          en[d][c]   = ($urandom_range(0, 4) != 0);
        end
      end
      tick();
      for (int d = 0; d < ND; d++) check_model(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
